// File: rtl/alu_mul_sequencer.sv
// ---------------------------------------------------------------------------
// alu_mul_sequencer
//
// Shift-and-add 32x32 -> 32 (low word) multiplier. It owns no adder or
// shifter: every arithmetic step is delegated to a shared ALU through
// alu_src_a/alu_src_b/alu_ctrl, and the combinational alu_result of the
// same cycle is captured at the next rising edge.
//
// Each multiplier bit costs SHL+SHR (2 cycles), plus an ADD (1 cycle) when
// the bit is set. With EARLY_EXIT=1 the loop stops as soon as the shifted
// multiplier becomes zero; otherwise it always runs 32 iterations.
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       begin a multiply (only looked at while idle)
//   op_a, op_b  multiplicand / multiplier, captured with start
//   busy        high in every state except IDLE
//   done        one-cycle pulse in the DONE state
//   product     registered result, held until the next completed multiply
//   alu_src_a   shared ALU operand A
//   alu_src_b   shared ALU operand B
//   alu_ctrl    shared ALU function: 000 add, 001 shl, 101 shr
//   alu_result  shared ALU result (combinational, same cycle)
// ---------------------------------------------------------------------------
module alu_mul_sequencer #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic [31:0] alu_src_a,
  output logic [31:0] alu_src_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SHL = 3'b001;
  localparam logic [2:0] ALU_SHR = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mult_q, mult_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] product_q, product_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mult_q    <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mult_q    <= mult_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mult_d    = mult_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    alu_ctrl  = ALU_ADD;
    alu_src_a = '0;
    alu_src_b = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          mcand_d = op_a;
          mult_d  = op_b;
          cnt_d   = '0;
          if (EARLY_EXIT && (op_b == '0)) begin
            state_d = S_DONE;
          end else if (op_b[0]) begin
            state_d = S_ADD;
          end else begin
            state_d = S_SHL;
          end
        end
      end

      S_ADD: begin
        alu_ctrl  = ALU_ADD;
        alu_src_a = acc_q;
        alu_src_b = mcand_q;
        acc_d     = alu_result;
        state_d   = S_SHL;
      end

      S_SHL: begin
        alu_ctrl  = ALU_SHL;
        alu_src_a = mcand_q;
        alu_src_b = 32'd1;
        mcand_d   = alu_result;
        state_d   = S_SHR;
      end

      S_SHR: begin
        alu_ctrl  = ALU_SHR;
        alu_src_a = mult_q;
        alu_src_b = 32'd1;
        mult_d    = alu_result;
        cnt_d     = cnt_q + 6'd1;
        // Exit decision uses the freshly shifted multiplier from the ALU,
        // so the next bit to examine is alu_result[0], not mult_q[1].
        if ((cnt_q == 6'd31) || (EARLY_EXIT && (alu_result == '0))) begin
          state_d = S_DONE;
        end else if (alu_result[0]) begin
          state_d = S_ADD;
        end else begin
          state_d = S_SHL;
        end
      end

      S_DONE: begin
        product_d = acc_q;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: doc/alu_mul_sequencer.md
ALU_MUL_SEQUENCER -- requirements
Module: alu_mul_sequencer

Interface
REQ-001 The block SHALL have parameter EARLY_EXIT, default 1, meaning terminate when the remaining multiplier reaches zero (0 = always run 32 iterations).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1, request to begin a multiply; sampled only in IDLE.
REQ-005 The block SHALL have port op_a, input, 32, multiplicand, sampled with start.
REQ-006 The block SHALL have port op_b, input, 32, multiplier, sampled with start.
REQ-007 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 The block SHALL have port done, output, 1, one-cycle pulse when product is valid.
REQ-009 The block SHALL have port product, output, 32, low 32 bits of op_a*op_b, registered, held until the next accepted start.
REQ-010 The block SHALL have port alu_src_a, output, 32, drives the shared ALU SrcA.
REQ-011 The block SHALL have port alu_src_b, output, 32, drives the shared ALU SrcB.
REQ-012 The block SHALL have port alu_ctrl, output, 3, drives ALUControl (000 add, 001 shl, 101 shr).
REQ-013 The block SHALL have port alu_result, input, 32, combinational ALUResult of the same cycle.

Function
REQ-014 The block SHALL keep internal registers acc, mcand, mult (32 bits each) and a 6-bit iteration count cnt.
REQ-015 The block SHALL implement states IDLE, ADD, SHL, SHR, DONE.
REQ-016 IDLE: start=1 -> acc=0, mcand=op_a, mult=op_b, cnt=0; next state DONE if EARLY_EXIT=1 and op_b=0, else ADD if op_b[0]=1, else SHL.
REQ-017 ADD: alu_ctrl=000, alu_src_a=acc, alu_src_b=mcand; acc<=alu_result; next SHL.
REQ-018 SHL: alu_ctrl=001, alu_src_a=mcand, alu_src_b=1; mcand<=alu_result; next SHR.
REQ-019 SHR: alu_ctrl=101, alu_src_a=mult, alu_src_b=1; mult<=alu_result; cnt<=cnt+1.
REQ-020 SHR exit: next DONE if cnt=31 or (EARLY_EXIT=1 and alu_result=0); else ADD if alu_result[0]=1; else SHL.
REQ-021 DONE: product<=acc, done=1 for exactly that cycle; next IDLE unconditionally.
REQ-022 In IDLE and DONE, alu_ctrl=000, alu_src_a=0, alu_src_b=0.
REQ-023 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-024 start in the IDLE cycle immediately following DONE SHALL be accepted normally, giving back-to-back operations.
REQ-025 Arithmetic SHALL be modulo 2^32; overflow bits are discarded, with no flag.
REQ-026 Latency from the accept edge to done: 1 + 3*(iterations with multiplier bit=1) + 2*(iterations with bit=0) cycles, where iterations are 32 when EARLY_EXIT=0 or index of highest set bit of op_b + 1 when EARLY_EXIT=1.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, product=0, acc=mcand=mult=0, cnt=0, alu_ctrl=000, alu_src_a=alu_src_b=0.
REQ-028 Reset mid-operation SHALL abandon the operation; no done pulse is produced and product reads 0.
REQ-029 After rst_n rises, the first rising clk edge with start=1 SHALL be accepted.

Verification
REQ-030 The bench SHALL cover: op_a=3, op_b=5, EARLY_EXIT=1 -> ALU sequence ADD,SHL,SHR,SHL,SHR,ADD,SHL,SHR; done on cycle 9 after accept; product=15.
REQ-031 The bench SHALL cover: op_a=7, op_b=0, EARLY_EXIT=1 -> done 1 cycle after accept, product=0; with EARLY_EXIT=0 -> done 65 cycles after accept, product=0.
REQ-032 The bench SHALL cover: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF, EARLY_EXIT=0 -> done 97 cycles after accept, product=0x00000001 (wrap).
REQ-033 The bench SHALL cover: start pulsed with op_a=9, op_b=9 while busy during an op_a=2, op_b=6 multiply -> product=12, busy timing unchanged, the second request is not executed.
REQ-034 The bench SHALL cover: rst_n low for 1 cycle during SHL of a 3*5 multiply -> all outputs 0 asynchronously, no done; a subsequent 4*4 multiply gives product=16.
REQ-035 The bench SHALL cover: a back-to-back start in the cycle after done, with 6*7 then 2*3 -> products 42 then 6, each with exactly one done pulse.
